// File: rtl/xilinx_board_status_ctrl.sv
// rtl/xilinx_board_status_ctrl.sv - board reset sync, heartbeat LED and SoC exit-status display
module xilinx_board_status_ctrl #(
    parameter int CLK_LED_COUNT_LENGTH = 27,
    parameter int RST_SYNC_STAGES      = 2,
    parameter int NUM_LEDS             = 4,
    parameter int FAIL_BLINK_SHIFT     = 22,
    parameter int CODE_BITS            = 4
) (
    input  logic                clk_gen,
    input  logic                rst_n,
    input  logic                exit_valid_i,
    input  logic [31:0]         exit_value_i,
    input  logic                clear_i,
    output logic                rst_sync_no,
    output logic                rst_led_o,
    output logic                clk_led_o,
    output logic [NUM_LEDS-1:0] status_led_o,
    output logic [31:0]         exit_latched_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_ON   = 2'd1,
        PH_OFF  = 2'd2,
        PH_GAP  = 2'd3
    } phase_t;

    localparam logic [NUM_LEDS-1:0] LED_FAIL_BASE = {1'b1, {(NUM_LEDS-1){1'b0}}};
    localparam logic [CODE_BITS:0]  CODE_WRAP     = {1'b1, {CODE_BITS{1'b0}}};
    localparam logic [1:0]          GAP_LAST      = 2'd3;

    logic [RST_SYNC_STAGES-1:0]      rst_sync;
    logic [CLK_LED_COUNT_LENGTH-1:0] cnt;
    logic                            valid_q;
    logic                            tick;
    logic                            exit_edge;
    logic [CODE_BITS:0]              code_count;
    state_t                          state;
    phase_t                          phase;
    logic [CODE_BITS:0]              pulse_cnt;
    logic [1:0]                      gap_cnt;

    // Async assert, sync deassert; everything downstream is reset from rst_sync_no.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_no = rst_sync[RST_SYNC_STAGES-1];
    assign rst_led_o   = rst_sync_no;

    always_ff @(posedge clk_gen or negedge rst_sync_no) begin
        if (!rst_sync_no) begin
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            valid_q <= exit_valid_i;
        end
    end

    assign clk_led_o = cnt[CLK_LED_COUNT_LENGTH-1];
    assign tick      = (cnt[FAIL_BLINK_SHIFT-1:0] == {FAIL_BLINK_SHIFT{1'b1}});
    assign exit_edge = exit_valid_i & ~valid_q;

    // A zero code would be invisible, so it is shown as the full 2**CODE_BITS pulses.
    assign code_count = (exit_latched_o[CODE_BITS-1:0] == '0) ? CODE_WRAP
                                                              : {1'b0, exit_latched_o[CODE_BITS-1:0]};

    assign state_o = state;

    always_ff @(posedge clk_gen or negedge rst_sync_no) begin
        if (!rst_sync_no) begin
            state          <= S_RUN;
            phase          <= PH_IDLE;
            pulse_cnt      <= '0;
            gap_cnt        <= '0;
            exit_latched_o <= '0;
            status_led_o   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (exit_edge) begin
                        exit_latched_o <= exit_value_i;
                        phase          <= PH_IDLE;
                        pulse_cnt      <= '0;
                        gap_cnt        <= '0;
                        if (exit_value_i == 32'd0) begin
                            state        <= S_PASS;
                            status_led_o <= '1;
                        end else begin
                            state        <= S_FAIL;
                            status_led_o <= LED_FAIL_BASE;
                        end
                    end
                end
                S_PASS: begin
                    if (clear_i) begin
                        state          <= S_RUN;
                        exit_latched_o <= '0;
                        status_led_o   <= '0;
                    end
                end
                S_FAIL: begin
                    if (clear_i) begin
                        state          <= S_RUN;
                        exit_latched_o <= '0;
                        status_led_o   <= '0;
                        phase          <= PH_IDLE;
                        pulse_cnt      <= '0;
                        gap_cnt        <= '0;
                    end else if (tick) begin
                        // Each tick closes one slot: ON/OFF pairs, then the GAP slots.
                        case (phase)
                            PH_IDLE: begin
                                phase           <= PH_ON;
                                pulse_cnt       <= {{CODE_BITS{1'b0}}, 1'b1};
                                status_led_o[0] <= 1'b1;
                            end
                            PH_ON: begin
                                phase           <= PH_OFF;
                                status_led_o[0] <= 1'b0;
                            end
                            PH_OFF: begin
                                if (pulse_cnt == code_count) begin
                                    phase   <= PH_GAP;
                                    gap_cnt <= '0;
                                end else begin
                                    phase           <= PH_ON;
                                    pulse_cnt       <= pulse_cnt + 1'b1;
                                    status_led_o[0] <= 1'b1;
                                end
                            end
                            PH_GAP: begin
                                if (gap_cnt == GAP_LAST) begin
                                    phase           <= PH_ON;
                                    pulse_cnt       <= {{CODE_BITS{1'b0}}, 1'b1};
                                    gap_cnt         <= '0;
                                    status_led_o[0] <= 1'b1;
                                end else begin
                                    gap_cnt <= gap_cnt + 1'b1;
                                end
                            end
                            default: phase <= PH_IDLE;
                        endcase
                    end
                end
                default: begin
                    state        <= S_RUN;
                    status_led_o <= '0;
                end
            endcase
        end
    end

endmodule
